// File: rtl/gauss_scan_ctrl.sv
// Frame scheduler for the 3x3 Gaussian filter: raster-order frame-buffer reads,
// filter strobes aligned to read latency, and result-buffer write addressing.
module gauss_scan_ctrl #(
   parameter int unsigned H_ACTIVE   = 320,
   parameter int unsigned V_ACTIVE   = 240,
   parameter int unsigned H_BLANK    = 4,
   parameter int unsigned V_SYNC_LEN = 8,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned WR_COL_OFS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        continuous,
   input  logic        abort,
   output logic [16:0] rd_addr,
   output logic        rd_en,
   output logic        filt_enable,
   output logic        filt_vsync,
   output logic        filt_active,
   input  logic        filt_ready,
   output logic [16:0] wr_addr,
   output logic        wr_en,
   output logic        busy,
   output logic        frame_done,
   output logic        overrun
);

   localparam int unsigned ADDR_W  = 17;
   localparam int unsigned CNT_MAX = (H_ACTIVE > H_BLANK)
                                     ? ((H_ACTIVE > V_SYNC_LEN) ? H_ACTIVE : V_SYNC_LEN)
                                     : ((H_BLANK > V_SYNC_LEN) ? H_BLANK : V_SYNC_LEN);
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam int unsigned ROW_W   = $clog2(V_ACTIVE + 1);
   localparam int unsigned COL_W   = $clog2(H_ACTIVE + 1);
   localparam logic [ADDR_W-1:0] RD_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_VSYNC,
      S_ACTIVE,
      S_BLANK,
      S_FRAME_END
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                rd_en_q, rd_en_d;
   logic                vsync_q, vsync_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [RD_LAT-1:0]   act_sh_q, act_sh_d;
   logic                fa_prev_q, fa_prev_d;
   logic [ROW_W-1:0]    wr_row_q, wr_row_d;
   logic [ADDR_W-1:0]   wr_base_q, wr_base_d;
   logic [COL_W-1:0]    wr_col_q, wr_col_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic                overrun_q, overrun_d;

   logic                fa, fa_rise, fa_fall, abort_hit, accept, vsync_entry;
   logic [COL_W-1:0]    col_eff;

   assign fa          = act_sh_q[RD_LAT-1];
   assign fa_rise     = fa & ~fa_prev_q;
   assign fa_fall     = ~fa & fa_prev_q;
   assign abort_hit   = abort && (state_q != S_IDLE);
   assign accept      = (state_q == S_IDLE) && start && !abort;
   assign vsync_entry = (state_d == S_VSYNC) && (state_q != S_VSYNC);
   // A result coinciding with the line's first active cycle already uses the reset column
   assign col_eff     = fa_rise ? COL_W'(WR_COL_OFS) : wr_col_q;

   // Frame sequencing and read side
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      row_d     = row_q;
      rd_addr_d = rd_addr_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_VSYNC;
               cnt_d   = '0;
            end
         end
         S_VSYNC: begin
            if (cnt_q == CNT_W'(V_SYNC_LEN - 1)) begin
               state_d = S_ACTIVE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ACTIVE: begin
            if (cnt_q == CNT_W'(H_ACTIVE - 1)) begin
               state_d = S_BLANK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_BLANK: begin
            if (cnt_q == CNT_W'(H_BLANK - 1)) begin
               cnt_d = '0;
               if (row_q < ROW_W'(V_ACTIVE - 1)) begin
                  state_d = S_ACTIVE;
                  row_d   = row_q + ROW_W'(1);
               end else begin
                  state_d = S_FRAME_END;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FRAME_END: begin
            state_d = continuous ? S_VSYNC : S_IDLE;
            cnt_d   = '0;
            row_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
            row_d   = '0;
         end
      endcase

      if (abort_hit) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         row_d   = '0;
      end
      if (vsync_entry) begin
         row_d = '0;
      end

      // Raster addresses are contiguous, so each line simply continues from the last
      if (state_d == S_ACTIVE) begin
         if (state_q == S_VSYNC) begin
            rd_addr_d = '0;
         end else if (rd_addr_q != RD_LAST) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
         end
      end

      rd_en_d  = (state_d == S_ACTIVE);
      vsync_d  = (state_d == S_VSYNC);
      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_FRAME_END);
      act_sh_d = abort_hit ? '0 : RD_LAT'({act_sh_q, rd_en_q});
   end

   // Write side: filter results to result-buffer addresses
   always_comb begin
      fa_prev_d = abort_hit ? 1'b0 : fa;
      wr_row_d  = wr_row_q;
      wr_base_d = wr_base_q;
      wr_col_d  = wr_col_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      overrun_d = overrun_q;

      if (fa_rise) begin
         wr_col_d = COL_W'(WR_COL_OFS);
      end
      if (fa_fall && (state_q != S_VSYNC) && (wr_row_q != ROW_W'(V_ACTIVE - 1))) begin
         wr_row_d  = wr_row_q + ROW_W'(1);
         wr_base_d = wr_base_q + ADDR_W'(H_ACTIVE);
      end
      if (filt_ready && (state_q != S_IDLE) && !abort) begin
         if (col_eff == COL_W'(H_ACTIVE)) begin
            overrun_d = 1'b1;
         end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = wr_base_q + ADDR_W'(col_eff);
            wr_col_d  = col_eff + COL_W'(1);
         end
      end
      if (accept) begin
         overrun_d = 1'b0;
      end
      if (vsync_entry) begin
         wr_row_d  = '0;
         wr_base_d = '0;
         wr_col_d  = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         row_q     <= '0;
         rd_addr_q <= '0;
         rd_en_q   <= 1'b0;
         vsync_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         act_sh_q  <= '0;
         fa_prev_q <= 1'b0;
         wr_row_q  <= '0;
         wr_base_q <= '0;
         wr_col_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         row_q     <= row_d;
         rd_addr_q <= rd_addr_d;
         rd_en_q   <= rd_en_d;
         vsync_q   <= vsync_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         act_sh_q  <= act_sh_d;
         fa_prev_q <= fa_prev_d;
         wr_row_q  <= wr_row_d;
         wr_base_q <= wr_base_d;
         wr_col_q  <= wr_col_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         overrun_q <= overrun_d;
      end
   end

   assign rd_addr     = rd_addr_q;
   assign rd_en       = rd_en_q;
   assign filt_enable = busy_q;
   assign filt_vsync  = vsync_q;
   assign filt_active = fa;
   assign wr_addr     = wr_addr_q;
   assign wr_en       = wr_en_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_gauss_scan_ctrl.sv
// Scoreboard bench for gauss_scan_ctrl with an 8x3 frame; a second instance
// with a 3-cycle read latency checks filt_active alignment.
module tb_gauss_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, continuous, abort, filt_ready;
   logic        start_b;
   logic [16:0] rd_addr, wr_addr, rd_addr_b, wr_addr_b;
   logic        rd_en, f_en, f_vs, f_act, wr_en, busy, done, ovr;
   logic        rd_en_b, f_en_b, f_vs_b, f_act_b, wr_en_b, busy_b, done_b, ovr_b;

   int cyc = 0;
   int nchk = 0;
   int nerr = 0;
   int rd_q[$];
   int wr_q[$];
   int done_q[$];
   int fa_q[$];
   int rises_b = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gauss_scan_ctrl #(.H_ACTIVE(8), .V_ACTIVE(3), .H_BLANK(2), .V_SYNC_LEN(2), .RD_LAT(1), .WR_COL_OFS(1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
      .rd_addr(rd_addr), .rd_en(rd_en), .filt_enable(f_en), .filt_vsync(f_vs), .filt_active(f_act),
      .filt_ready(filt_ready), .wr_addr(wr_addr), .wr_en(wr_en), .busy(busy),
      .frame_done(done), .overrun(ovr)
   );

   gauss_scan_ctrl #(.H_ACTIVE(8), .V_ACTIVE(3), .H_BLANK(2), .V_SYNC_LEN(2), .RD_LAT(3), .WR_COL_OFS(1)) u_dut_lat3 (
      .clk(clk), .rst(rst), .start(start_b), .continuous(1'b0), .abort(1'b0),
      .rd_addr(rd_addr_b), .rd_en(rd_en_b), .filt_enable(f_en_b), .filt_vsync(f_vs_b), .filt_active(f_act_b),
      .filt_ready(1'b0), .wr_addr(wr_addr_b), .wr_en(wr_en_b), .busy(busy_b),
      .frame_done(done_b), .overrun(ovr_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_zero(input string name);
      logic [41:0] v;
      v = {rd_addr, wr_addr, rd_en, f_en, f_vs, f_act, wr_en, busy, done, ovr};
      nchk++;
      if (v != '0) begin
         nerr++;
         $display("FAIL %s: outputs=%h, expected all zero", name, v);
      end
   endtask

   task automatic unexpected(input string name, input int val);
      nchk++;
      nerr++;
      $display("FAIL %s: got %0d, expected no event (cycle %0d)", name, val, cyc);
   endtask

   task automatic wait_cyc(input int k);
      while (cyc < k) @(negedge clk);
   endtask

   task automatic push_rd(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) rd_q.push_back(i);
   endtask

   task automatic pulse_start(input bit with_b, output int s);
      @(negedge clk);
      s       = cyc;
      start   = 1'b1;
      start_b = with_b;
      @(negedge clk);
      start   = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_rd_left"}, rd_q.size(), 0);
      chk({tag, "_wr_left"}, wr_q.size(), 0);
      chk({tag, "_done_left"}, done_q.size(), 0);
   endtask

   // Monitor: pop expected read/write addresses and frame_done cycles as the DUT presents them
   always @(negedge clk) begin
      if (rd_en) begin
         if (rd_q.size() == 0) unexpected("rd_unexpected", int'(rd_addr));
         else chk("rd_addr", int'(rd_addr), rd_q.pop_front());
      end
      if (wr_en) begin
         if (wr_q.size() == 0) unexpected("wr_unexpected", int'(wr_addr));
         else chk("wr_addr", int'(wr_addr), wr_q.pop_front());
      end
      if (done) begin
         if (done_q.size() == 0) unexpected("done_unexpected", cyc);
         else chk("frame_done_cycle", cyc, done_q.pop_front());
      end
   end

   // Latency monitor for the RD_LAT=3 instance
   bit rd_b_prev = 1'b0, fa_b_prev = 1'b0;
   int rd_run = 0, fa_run = 0;
   always @(negedge clk) begin
      if (rd_en_b && !rd_b_prev) fa_q.push_back(cyc + 3);
      if (f_act_b && !fa_b_prev) begin
         rises_b++;
         if (fa_q.size() == 0) unexpected("fa_rise_unexpected", cyc);
         else chk("fa_rise_cycle", cyc, fa_q.pop_front());
      end
      if (rd_en_b) rd_run++;
      else if (rd_b_prev) begin
         chk("rd_en_width", rd_run, 8);
         rd_run = 0;
      end
      if (f_act_b) fa_run++;
      else if (fa_b_prev) begin
         chk("fa_width", fa_run, 8);
         fa_run = 0;
      end
      rd_b_prev = rd_en_b;
      fa_b_prev = f_act_b;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int s, s2;
      rst = 1'b1; start = 1'b0; start_b = 1'b0; continuous = 1'b0; abort = 1'b0; filt_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_zero("reset_state");
      chk("reset_b_busy", int'(busy_b), 0);
      rst = 1'b0;

      // Single frame, plus latency instance; a mid-frame start must be ignored
      push_rd(0, 23);
      pulse_start(1'b1, s);
      done_q.push_back(s + 33);
      chk("vs_c1", int'(f_vs), 1);
      chk("busy_c1", int'(busy), 1);
      chk("fen_c1", int'(f_en), 1);
      wait_cyc(s + 2);
      chk("vs_c2", int'(f_vs), 1);
      wait_cyc(s + 3);
      chk("vs_c3", int'(f_vs), 0);
      chk("rd_en_first", int'(rd_en), 1);
      wait_cyc(s + 10);
      start = 1'b1;
      wait_cyc(s + 11);
      start = 1'b0;
      wait_cyc(s + 35);
      chk("busy_after", int'(busy), 0);
      chk("fen_after", int'(f_en), 0);
      chk_drained("single");
      chk("lat3_rises", rises_b, 3);
      chk("lat3_fa_left", fa_q.size(), 0);

      // Write mapping: 6 ready cycles inside line 1
      push_rd(0, 23);
      for (int a = 9; a <= 14; a++) wr_q.push_back(a);
      pulse_start(1'b0, s);
      done_q.push_back(s + 33);
      wait_cyc(s + 15);
      filt_ready = 1'b1;
      wait_cyc(s + 16);
      chk("wr_en_latency", int'(wr_en), 1);
      wait_cyc(s + 21);
      filt_ready = 1'b0;
      wait_cyc(s + 35);
      chk("ovr_clean", int'(ovr), 0);
      chk_drained("write");

      // Overrun: 9 ready cycles across line 0
      push_rd(0, 23);
      for (int a = 1; a <= 7; a++) wr_q.push_back(a);
      pulse_start(1'b0, s);
      done_q.push_back(s + 33);
      wait_cyc(s + 5);
      filt_ready = 1'b1;
      wait_cyc(s + 13);
      chk("ovr_set", int'(ovr), 1);
      chk("wr_suppressed", int'(wr_en), 0);
      wait_cyc(s + 14);
      filt_ready = 1'b0;
      wait_cyc(s + 35);
      chk("ovr_sticky", int'(ovr), 1);
      chk_drained("overrun");

      // start and abort together while idle: abort wins
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("start_abort_busy", int'(busy), 0);
      chk("start_abort_vs", int'(f_vs), 0);

      // Continuous frame, then abort in line 1 of the second frame
      continuous = 1'b1;
      push_rd(0, 23);
      push_rd(0, 10);
      pulse_start(1'b0, s);
      done_q.push_back(s + 33);
      chk("ovr_cleared_by_start", int'(ovr), 0);
      wait_cyc(s + 34);
      continuous = 1'b0;
      chk("cont_vsync", int'(f_vs), 1);
      chk("cont_busy", int'(busy), 1);
      s2 = s + 33;
      wait_cyc(s2 + 15);
      abort = 1'b1;
      filt_ready = 1'b1;
      wait_cyc(s2 + 16);
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_rd_en", int'(rd_en), 0);
      chk("abort_fa", int'(f_act), 0);
      chk("abort_wr_en", int'(wr_en), 0);
      chk("abort_vs", int'(f_vs), 0);
      chk("abort_fen", int'(f_en), 0);
      wait_cyc(s2 + 17);
      filt_ready = 1'b0;
      chk("abort_wr_en2", int'(wr_en), 0);
      wait_cyc(s2 + 40);
      chk_drained("abort");

      // Asynchronous reset mid-ACTIVE, then a clean frame
      push_rd(0, 2);
      pulse_start(1'b0, s);
      wait_cyc(s + 5);
      #2 rst = 1'b1;
      #1 chk_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      chk_drained("rst_partial");
      push_rd(0, 23);
      pulse_start(1'b0, s);
      done_q.push_back(s + 33);
      wait_cyc(s + 3);
      chk("post_rst_rd_en", int'(rd_en), 1);
      wait_cyc(s + 35);
      chk("post_rst_busy", int'(busy), 0);
      chk_drained("post_rst");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
